// File: rtl/lifm_column_gen.sv
// LIFM column generator: walks an IFM in SRAM and emits one column per kernel element.
// Output coordinates advance incrementally; each column is handed off over valid/ready.
module lifm_column_gen #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [WORD_WIDTH-1:0]            ke_width,
  input  logic [WORD_WIDTH-1:0]            ke_height,
  input  logic [WORD_WIDTH-1:0]            of_width,
  input  logic [WORD_WIDTH-1:0]            if_width,
  input  logic [WORD_WIDTH-1:0]            stride,
  input  logic [WORD_WIDTH-1:0]            base_ox,
  input  logic [WORD_WIDTH-1:0]            base_oy,
  input  logic [WORD_WIDTH:0]              num_pos,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [WORD_WIDTH-1:0]            mem_rdata,
  output logic                             col_valid,
  input  logic                             col_ready,
  output logic [WORD_WIDTH-1:0]            kidx,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column,
  output logic                             busy,
  output logic                             done
);
  localparam int W  = WORD_WIDTH;
  localparam int LW = $clog2(STEP_RANGE + 1);
  localparam int MW = 3 * WORD_WIDTH + 2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUTPUT, S_DONE} state_t;

  state_t                r_state;
  logic [W-1:0]          r_fw, r_ow, r_iw, r_s, r_box, r_boy, r_klast;
  logic [W-1:0]          r_kx, r_ky, r_kidx, r_ox, r_oy;
  logic [LW-1:0]         r_n, r_issue, r_cap_lane;
  logic                  r_cap_en;
  logic                  r_mem_rd_en, r_col_valid, r_busy, r_done;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic [LW-1:0]         w_n_in;
  logic                  w_kzero, w_last, w_clear;
  logic [W-1:0]          w_kx_nxt, w_ky_nxt;
  logic [2*W-1:0]        w_prod;

  // Full-width address arithmetic; only the final word address is truncated.
  function automatic logic [ADDR_WIDTH-1:0] addr_calc(input logic [W-1:0] ox, oy, ky, kx, s, iw);
    logic [MW-1:0] row, col, full;
    row  = MW'(oy) * MW'(s) + MW'(ky);
    col  = MW'(ox) * MW'(s) + MW'(kx);
    full = row * MW'(iw) + col;
    return ADDR_WIDTH'(full);
  endfunction

  // Returns {oy, ox} of the following output position, wrapping at the row end.
  function automatic logic [2*W-1:0] next_pos(input logic [W-1:0] ox, oy, ow);
    if (ox + 1'b1 == ow) return {oy + 1'b1, {W{1'b0}}};
    return {oy, ox + 1'b1};
  endfunction

  always_comb begin
    w_n_in   = (num_pos > (W+1)'(STEP_RANGE)) ? LW'(STEP_RANGE) : LW'(num_pos);
    w_kzero  = (ke_width == '0) || (ke_height == '0);
    w_prod   = (2*W)'(ke_width) * (2*W)'(ke_height);
    w_last   = (r_kidx == r_klast);
    w_kx_nxt = r_kx + 1'b1;
    w_ky_nxt = r_ky;
    if (w_kx_nxt == r_fw) begin
      w_kx_nxt = '0;
      w_ky_nxt = r_ky + 1'b1;
    end
    w_clear  = (r_state == S_IDLE && start && !w_kzero) ||
               (r_state == S_OUTPUT && col_ready && !w_last);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_fw        <= '0;
      r_ow        <= '0;
      r_iw        <= '0;
      r_s         <= '0;
      r_box       <= '0;
      r_boy       <= '0;
      r_klast     <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      r_kidx      <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_n         <= '0;
      r_issue     <= '0;
      r_cap_lane  <= '0;
      r_cap_en    <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_col_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe, so capture trails issue by one.
      r_cap_en   <= r_mem_rd_en;
      r_cap_lane <= r_issue;
      case (r_state)
        S_IDLE: if (start) begin
          r_fw    <= ke_width;
          r_ow    <= of_width;
          r_iw    <= if_width;
          r_s     <= stride;
          r_box   <= base_ox;
          r_boy   <= base_oy;
          r_klast <= W'(w_prod - 1'b1);
          r_n     <= w_n_in;
          r_kx    <= '0;
          r_ky    <= '0;
          r_kidx  <= '0;
          r_issue <= '0;
          r_busy  <= 1'b1;
          if (w_kzero) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_n_in == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state     <= S_FETCH;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= addr_calc(base_ox, base_oy, '0, '0, stride, if_width);
            {r_oy, r_ox} <= next_pos(base_ox, base_oy, of_width);
          end
        end
        S_FETCH: begin
          if (r_issue + LW'(1) < r_n) begin
            r_issue      <= r_issue + LW'(1);
            r_mem_addr   <= addr_calc(r_ox, r_oy, r_ky, r_kx, r_s, r_iw);
            {r_oy, r_ox} <= next_pos(r_ox, r_oy, r_ow);
          end else begin
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_state     <= S_OUTPUT;
          r_col_valid <= 1'b1;
        end
        S_OUTPUT: if (col_ready) begin
          r_col_valid <= 1'b0;
          r_kidx      <= r_kidx + 1'b1;
          r_kx        <= w_kx_nxt;
          r_ky        <= w_ky_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_n == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state      <= S_FETCH;
            r_issue      <= '0;
            r_mem_rd_en  <= 1'b1;
            r_mem_addr   <= addr_calc(r_box, r_boy, w_ky_nxt, w_kx_nxt, r_s, r_iw);
            {r_oy, r_ox} <= next_pos(r_box, r_boy, r_ow);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STEP_RANGE; gi++) begin : g_lane
      logic [W-1:0] r_lane;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  r_lane <= '0;
        else if (w_clear)                              r_lane <= '0;
        else if (r_cap_en && (r_cap_lane == LW'(gi)))  r_lane <= mem_rdata;
      end
      assign lifm_column[gi*W +: W] = r_lane;
    end
  endgenerate

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign col_valid = r_col_valid;
  assign kidx      = r_kidx;
  assign busy      = r_busy;
  assign done      = r_done;
endmodule
